// File: rtl/llc_mshr_table.sv
// Parametrised LLC miss-status holding register table: allocate, lookup, update,
// free, completion tracking, occupancy and sticky protocol-error flag.
module llc_mshr_table #(
   parameter  int N_ENTRIES  = 8,
   parameter  int ADDR_BITS  = 26,
   parameter  int SET_BITS   = 9,
   parameter  int STATE_BITS = 4,
   parameter  int ID_BITS    = 5,
   parameter  int WM_BITS    = 4,
   parameter  int CNT_BITS   = 4,
   localparam int IDXW       = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
   localparam int OCCW       = $clog2(N_ENTRIES + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_alloc_valid,
   output logic                  o_alloc_ready,
   input  logic [ADDR_BITS-1:0]  i_alloc_addr,
   input  logic [STATE_BITS-1:0] i_alloc_state,
   input  logic [ID_BITS-1:0]    i_alloc_req_id,
   input  logic [WM_BITS-1:0]    i_alloc_word_mask,
   input  logic [CNT_BITS-1:0]   i_alloc_invack_cnt,
   output logic [IDXW-1:0]       o_alloc_idx,
   input  logic [ADDR_BITS-1:0]  i_lookup_addr,
   output logic                  o_lookup_hit,
   output logic [IDXW-1:0]       o_lookup_idx,
   output logic [STATE_BITS-1:0] o_lookup_state,
   output logic [ID_BITS-1:0]    o_lookup_req_id,
   output logic [WM_BITS-1:0]    o_lookup_word_mask,
   output logic                  o_lookup_set_conflict,
   input  logic                  i_upd_valid,
   input  logic [IDXW-1:0]       i_upd_idx,
   input  logic                  i_upd_state_en,
   input  logic [STATE_BITS-1:0] i_upd_state,
   input  logic [WM_BITS-1:0]    i_upd_wm_clr,
   input  logic                  i_upd_invack_dec,
   input  logic                  i_free_valid,
   input  logic [IDXW-1:0]       i_free_idx,
   output logic                  o_done_valid,
   output logic [IDXW-1:0]       o_done_idx,
   output logic [OCCW-1:0]       o_occupancy,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_err
);

   localparam logic [OCCW-1:0] OCC_FULL = OCCW'(N_ENTRIES);

   logic [N_ENTRIES-1:0]  r_valid;
   logic [ADDR_BITS-1:0]  r_addr  [N_ENTRIES];
   logic [STATE_BITS-1:0] r_state [N_ENTRIES];
   logic [ID_BITS-1:0]    r_req_id[N_ENTRIES];
   logic [WM_BITS-1:0]    r_wm    [N_ENTRIES];
   logic [CNT_BITS-1:0]   r_cnt   [N_ENTRIES];
   logic [OCCW-1:0]       r_occ;
   logic                  r_err;

   logic                  w_dup;
   logic [IDXW-1:0]       w_grant;
   logic                  w_hit;
   logic [IDXW-1:0]       w_hit_idx;
   logic [STATE_BITS-1:0] w_hit_state;
   logic [ID_BITS-1:0]    w_hit_req_id;
   logic [WM_BITS-1:0]    w_hit_wm;
   logic                  w_set_conflict;
   logic                  w_done;
   logic [IDXW-1:0]       w_done_idx;
   logic                  w_upd_tgt_valid;
   logic                  w_upd_cnt_zero;
   logic                  w_free_tgt_valid;
   logic                  w_alloc_acc;
   logic                  w_free_ok;
   logic                  w_upd_ok;
   logic                  w_err_set;

   // Descending scan so the last assignment wins, leaving the lowest index.
   always_comb begin
      w_dup            = 1'b0;
      w_grant          = '0;
      w_hit            = 1'b0;
      w_hit_idx        = '0;
      w_hit_state      = '0;
      w_hit_req_id     = '0;
      w_hit_wm         = '0;
      w_set_conflict   = 1'b0;
      w_done           = 1'b0;
      w_done_idx       = '0;
      w_upd_tgt_valid  = 1'b0;
      w_upd_cnt_zero   = 1'b0;
      w_free_tgt_valid = 1'b0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_grant = IDXW'(i);
         end else begin
            if (r_addr[i] == i_alloc_addr) w_dup = 1'b1;
            if (r_addr[i] == i_lookup_addr) begin
               w_hit        = 1'b1;
               w_hit_idx    = IDXW'(i);
               w_hit_state  = r_state[i];
               w_hit_req_id = r_req_id[i];
               w_hit_wm     = r_wm[i];
            end
            if (r_addr[i][SET_BITS-1:0] == i_lookup_addr[SET_BITS-1:0]) w_set_conflict = 1'b1;
            if (r_wm[i] == '0 && r_cnt[i] == '0) begin
               w_done     = 1'b1;
               w_done_idx = IDXW'(i);
            end
            if (i_upd_idx == IDXW'(i)) begin
               w_upd_tgt_valid = 1'b1;
               w_upd_cnt_zero  = (r_cnt[i] == '0);
            end
            if (i_free_idx == IDXW'(i)) w_free_tgt_valid = 1'b1;
         end
      end
   end

   assign o_full        = (r_occ == OCC_FULL);
   assign o_empty       = (r_occ == '0);
   assign o_alloc_ready = !o_full && !w_dup;
   assign o_alloc_idx   = w_grant;

   assign w_alloc_acc = i_alloc_valid && o_alloc_ready;
   assign w_free_ok   = i_free_valid && w_free_tgt_valid;
   // A same-cycle free of the updated entry silently discards the update.
   assign w_upd_ok    = i_upd_valid && w_upd_tgt_valid && !(w_free_ok && (i_free_idx == i_upd_idx));
   assign w_err_set   = (i_upd_valid && !w_upd_tgt_valid)
                     || (i_free_valid && !w_free_tgt_valid)
                     || (w_upd_ok && i_upd_invack_dec && w_upd_cnt_zero);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= '0;
         r_occ   <= '0;
         r_err   <= 1'b0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            r_addr[i]   <= '0;
            r_state[i]  <= '0;
            r_req_id[i] <= '0;
            r_wm[i]     <= '0;
            r_cnt[i]    <= '0;
         end
      end else begin
         if (w_err_set) r_err <= 1'b1;
         r_occ <= r_occ + OCCW'(w_alloc_acc) - OCCW'(w_free_ok);
         for (int i = 0; i < N_ENTRIES; i++) begin
            if (w_free_ok && i_free_idx == IDXW'(i)) begin
               r_valid[i] <= 1'b0;
            end else if (w_upd_ok && i_upd_idx == IDXW'(i)) begin
               if (i_upd_state_en) r_state[i] <= i_upd_state;
               r_wm[i] <= r_wm[i] & ~i_upd_wm_clr;
               if (i_upd_invack_dec && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_BITS'(1);
            end
            if (w_alloc_acc && w_grant == IDXW'(i)) begin
               r_valid[i]  <= 1'b1;
               r_addr[i]   <= i_alloc_addr;
               r_state[i]  <= i_alloc_state;
               r_req_id[i] <= i_alloc_req_id;
               r_wm[i]     <= i_alloc_word_mask;
               r_cnt[i]    <= i_alloc_invack_cnt;
            end
         end
      end
   end

   assign o_lookup_hit          = w_hit;
   assign o_lookup_idx          = w_hit_idx;
   assign o_lookup_state        = w_hit_state;
   assign o_lookup_req_id       = w_hit_req_id;
   assign o_lookup_word_mask    = w_hit_wm;
   assign o_lookup_set_conflict = w_set_conflict;
   assign o_done_valid          = w_done;
   assign o_done_idx            = w_done_idx;
   assign o_occupancy           = r_occ;
   assign o_err                 = r_err;

endmodule

// File: doc/llc_mshr_table.md
Name: llc_mshr_table

Overview:
- Parametrised MSHR table for the next-generation LLC pipeline.
- Replaces the fixed-depth, opcode-driven MSHR bookkeeping with a generic table. Entry count, address, set, state, word-mask and invack-counter widths are all parameters.
- Adds exact-line hit lookup, set-conflict detection, per-entry completion tracking, occupancy reporting, and sticky protocol-error flagging.
- Sits between the LLC FSM (allocate, update, free) and the lookup/decode stage (query).

Parameters:
- N_ENTRIES, 8: number of MSHR entries; any value >= 2.
- ADDR_BITS, 26: line-address width.
- SET_BITS, 9: low-order set-index bits of the line address; must be < ADDR_BITS.
- STATE_BITS, 4: unstable-state encoding width.
- ID_BITS, 5: requester cache-id width.
- WM_BITS, 4: word-mask width (words per line).
- CNT_BITS, 4: invack counter width.
- Derived widths:
  - IDXW = max(1, clog2(N_ENTRIES)).
  - OCCW = clog2(N_ENTRIES+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- alloc_valid  in  1  allocate request
- alloc_ready  out  1  allocation accepted this cycle
- alloc_addr  in  ADDR_BITS  line address
- alloc_state  in  STATE_BITS  initial unstable state
- alloc_req_id  in  ID_BITS  requester id
- alloc_word_mask  in  WM_BITS  outstanding words
- alloc_invack_cnt  in  CNT_BITS  expected invacks
- alloc_idx  out  IDXW  index granted (valid when alloc_valid & alloc_ready)
- lookup_addr  in  ADDR_BITS  query address
- lookup_hit  out  1  valid entry with equal line address
- lookup_idx  out  IDXW  hit index
- lookup_state  out  STATE_BITS  state of hit entry
- lookup_req_id  out  ID_BITS  requester id of hit entry
- lookup_word_mask  out  WM_BITS  word mask of hit entry
- lookup_set_conflict  out  1  valid entry with equal set bits
- upd_valid  in  1  update request
- upd_idx  in  IDXW  entry to update
- upd_state_en  in  1  write upd_state
- upd_state  in  STATE_BITS  new state
- upd_wm_clr  in  WM_BITS  word-mask bits to clear
- upd_invack_dec  in  1  decrement invack counter
- free_valid  in  1  free request
- free_idx  in  IDXW  entry to free
- done_valid  out  1  some entry has mask==0 and invack==0
- done_idx  out  IDXW  lowest such index
- occupancy  out  OCCW  number of valid entries
- full  out  1  occupancy == N_ENTRIES
- empty  out  1  occupancy == 0
- err  out  1  sticky protocol error

Behaviour:
- **Reset.** On rst low, asynchronously:
  - all entry valid bits, fields, occupancy and err clear to 0.
  - Hence alloc_ready = 1, full = 0, empty = 1, done_valid = 0, lookup_hit = 0, lookup_set_conflict = 0.
  - All index and data outputs = 0.
- **Output timing.** All outputs are combinational from registered table state (zero-latency lookup). Writes become visible the cycle after the clock edge.
- **Allocation.**
  - alloc_ready = !full & !(exact-line match of alloc_addr against any valid entry). Duplicate lines are never allocated.
  - The granted entry is the lowest-index invalid entry, computed from pre-edge state.
  - On alloc_valid & alloc_ready, the entry is written with all alloc_* fields and its valid bit is set.
- **Lookup.**
  - If more than one entry hits, report the lowest index. This cannot occur in legal use.
  - On a miss, lookup_idx and all lookup data outputs are 0.
- **Update.** Applies only when upd_valid and entry upd_idx is valid:
  - state <= upd_state if upd_state_en;
  - word_mask <= word_mask & ~upd_wm_clr;
  - invack <= invack - 1 if upd_invack_dec, saturating at 0. Decrementing at 0 sets err.
- **Done tracking.** An entry is done when valid, word_mask == 0 and invack == 0. done_valid/done_idx report the lowest done entry; the FSM frees it explicitly.
- **Free.** free_valid clears the valid bit of free_idx.
- **Simultaneous events (same cycle):**
  - alloc + free: both apply; occupancy unchanged. The alloc cannot take the entry being freed, because the grant uses pre-edge state.
  - alloc when full with a free in the same cycle: alloc_ready = 0; the free still applies.
  - upd + free on the same idx: free wins; the update is discarded and no err is raised.
- **Protocol errors.** Each of the following is ignored and sets err:
  - upd on an invalid entry;
  - free on an invalid entry;
  - upd_idx or free_idx >= N_ENTRIES.
  - err clears only on reset.
- **Occupancy.** Updated as occupancy + (alloc accepted) - (legal free). It never wraps.
- **Reset mid-operation.** All in-flight entries are discarded; no outputs glitch to stale values after reset release.

Test Plan:
- Reset, then 8 allocs with addr 0x100..0x107 on consecutive cycles -> alloc_idx 0..7 in order; occupancy = 8; full = 1; alloc_ready = 0 on the 9th attempt.
- Alloc 0x2A3 (set 0x0A3), then lookup 0x2A3 -> lookup_hit = 1, idx 0. Then lookup 0x4A3 -> hit = 0, set_conflict = 1. A second alloc of 0x2A3 -> alloc_ready = 0.
- Entry with mask 4'b0110 and invack 2: clear 0010, then 0100, then two decs -> done_valid rises only after the second dec, done_idx = 0. A third dec -> err = 1 and invack stays 0.
- Table full; free idx 3 and alloc 0x300 in the same cycle -> alloc rejected, occupancy = 7. Next cycle alloc 0x300 -> alloc_idx = 3, occupancy = 8.
- upd and free to idx 2 in the same cycle -> entry invalid, err = 0. Then free idx 2 again -> err = 1, occupancy unchanged.
- Assert rst low with 5 valid entries mid-update -> next cycle occupancy = 0, empty = 1, lookup_hit = 0 for all previous addresses.
